// File: rtl/btn_debounce_sched_pkg.sv
// Shared types and sizing helpers for the scheduled button debouncer.
package btn_debounce_pkg;

  localparam int unsigned MAX_BTN = 16;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COMMIT
  } state_t;

  // Width that can hold the values 0..cycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_sched_if.sv
// Button/debounce signal bundle. 'rel' carries the release pulses because 'release' is a reserved word.
interface btn_debounce_sched_if #(
  parameter int unsigned N_BTN = 4
);
  localparam int unsigned GW = $clog2(N_BTN);

  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic             busy;
  logic [GW-1:0]    grant_id;

  modport master (output btn, input level, press, rel, busy, grant_id);
  modport slave  (input btn, output level, press, rel, busy, grant_id);
endinterface

// File: rtl/btn_debounce_sched_rr_pick.sv
// Combinational rotate-priority picker: first request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;

  always_comb begin
    // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit is the winner.
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rot[N-1-k]) off = (IW+1)'(N-1-k);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    valid = |req;
    idx   = IW'(sum);
  end

endmodule

// File: rtl/btn_debounce_sched.sv
// N-button debouncer sharing one settle counter via a round-robin scheduler.
// Optional auto-repeat of the last pressed button: define BTN_AUTO_REPEAT_EN.
module btn_debounce_sched
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input logic                  clk,
  input logic                  rstn,
  btn_debounce_sched_if.slave  bus
);

  localparam int unsigned GW = $clog2(N_BTN);
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1, sbtn, level, press, rel, cand;
  logic [N_BTN-1:0] commit_vec, rise_vec, fall_vec, rep_vec;
  state_t           state;
  logic [GW-1:0]    gid, gid_next, rr_ptr, pick_idx;
  logic             pick_valid;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1   <= '0;
      sbtn <= '0;
    end else begin
      s1   <= bus.btn;
      sbtn <= s1;
    end
  end

  assign cand     = sbtn ^ level;
  assign gid_next = (gid == GW'(N_BTN - 1)) ? '0 : gid + 1'b1;

  rr_pick #(
    .N  (N_BTN),
    .IW (GW)
  ) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      gid    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      level  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gid   <= pick_idx;
            cnt   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (sbtn[gid] == level[gid]) begin
            cnt    <= '0;
            rr_ptr <= gid_next;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= COMMIT;
          end
        end
        COMMIT: begin
          level[gid] <= sbtn[gid];
          rr_ptr     <= gid_next;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A bounce landing exactly on the commit cycle leaves level unchanged and emits nothing.
  always_comb begin
    commit_vec = '0;
    if (state == COMMIT && cand[gid]) commit_vec[gid] = 1'b1;
    rise_vec = commit_vec & sbtn;
    fall_vec = commit_vec & ~sbtn;
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RW = cnt_width(REPEAT_CYCLES);

  logic          rep_on, rep_fire;
  logic [GW-1:0] rep_idx;
  logic [RW-1:0] rep_cnt;

  assign rep_fire = rep_on && !(|rise_vec) && !fall_vec[rep_idx]
                    && (rep_cnt == RW'(REPEAT_CYCLES - 1));

  always_comb begin
    rep_vec = '0;
    if (rep_fire) rep_vec[rep_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_on  <= 1'b0;
      rep_idx <= '0;
      rep_cnt <= '0;
    end else if (|rise_vec) begin
      rep_on  <= 1'b1;
      rep_idx <= gid;
      rep_cnt <= '0;
    end else if (rep_on && fall_vec[rep_idx]) begin
      rep_on  <= 1'b0;
      rep_cnt <= '0;
    end else if (rep_on) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end
`else
  assign rep_vec = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      press <= '0;
      rel   <= '0;
    end else begin
      press <= rise_vec | rep_vec;
      rel   <= fall_vec;
    end
  end

  assign bus.level    = level;
  assign bus.press    = press;
  assign bus.rel      = rel;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = gid;

endmodule
